rf_write_scheduler: RTL and testbench
=====================================

RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning data width matching the register file write data.
REQ-002 The block SHALL have parameter A, default 3, meaning address width, giving depth 2**A.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset asserted).
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous soft-clear request.
REQ-006 The block SHALL have port req0_valid, input, 1 bit: requester 0 has a write pending.
REQ-007 The block SHALL have port req0_addr, input, A bits: requester 0 target register.
REQ-008 The block SHALL have port req0_data, input, N bits: requester 0 write data.
REQ-009 The block SHALL have port req0_ready, output, 1 bit: requester 0 write accepted this cycle.
REQ-010 The block SHALL have ports req1_valid, req1_addr, req1_data and req1_ready with the same directions and widths as REQ-006 to REQ-009, for requester 1.
REQ-011 The block SHALL have port we3, output, 1 bit: register file write enable.
REQ-012 The block SHALL have port wa3, output, A bits: register file write address.
REQ-013 The block SHALL have port wd3, output, N bits: register file write data.
REQ-014 The block SHALL have port grant_id, output, 1 bit: requester whose write is on the port when we3=1 in RUN.
REQ-015 The block SHALL have port init_done, output, 1 bit: high while in RUN.

Function
REQ-016 The block SHALL implement a two-state FSM: CLEAR -> RUN when the clear counter reaches 2**A-1; RUN -> CLEAR when clr=1.
REQ-017 In CLEAR, each rising edge SHALL register we3=1, wa3=counter and wd3=0, then increment the counter; the counter SHALL NOT wrap, and exit happens on the write of address 2**A-1.
REQ-018 In CLEAR, req0_ready and req1_ready SHALL be 0, and clr SHALL be ignored.
REQ-019 Entering CLEAR SHALL reset the clear counter to 0.
REQ-020 A transfer on requester i SHALL occur when reqi_valid=1 and reqi_ready=1 on the same edge.
REQ-021 ready SHALL be combinational from state, valids, clr and the round-robin pointer, with no dependency on addr or data.
REQ-022 In RUN with clr=0, exactly one ready SHALL assert when at least one valid is high:
- if only one valid is high, that requester gets ready;
- if both are high, the requester not equal to the pointer gets ready.
REQ-023 With no valid high, or with clr=1, both readies SHALL be 0.
REQ-024 The round-robin pointer SHALL update to the served requester id on each transfer and hold otherwise.
REQ-025 A transfer SHALL produce, one cycle later, we3=1 together with the transferred wa3, wd3 and grant_id; latency is exactly 1 cycle and throughput is 1 write per cycle.
REQ-026 In RUN with no transfer, the next cycle SHALL have we3=0, with wa3, wd3 and grant_id holding their last values.
REQ-027 init_done SHALL be registered and go to 1 on the same edge on which the FSM enters RUN.
REQ-028 A requester SHALL keep valid, addr and data stable until accepted; the block does not check this.

Reset
REQ-029 While rst=0, outputs SHALL immediately be: we3=0, wa3=0, wd3=0, grant_id=0, init_done=0, req0_ready=0, req1_ready=0.
REQ-030 While rst=0, internal state SHALL immediately be: state=CLEAR, clear counter=0, pointer=1, so that the first tie goes to requester 0.
REQ-031 A reset asserted mid-CLEAR or mid-RUN SHALL abort the operation; no pending write is retained.
REQ-032 After rst deasserts, the first edge SHALL present wa3=0 of the sweep.

Verification
REQ-033 Release rst with no requests -> edges 1..8 give we3=1, wa3=0..7, wd3=00; init_done=1 from edge 8; we3=0 from edge 9.
REQ-034 In RUN, req0 alone with addr=1 and data=AB -> req0_ready=1 that cycle; next cycle we3=1, wa3=1, wd3=AB, grant_id=0.
REQ-035 Both valid held in RUN (req0 addr=4 data=FF; req1 addr=2 data=11) -> grant_id sequence 0,1,0,1 with wa3 sequence 4,2,4,2.
REQ-036 clr=1 in RUN with both valid -> no ready that cycle, 8-write zero sweep, init_done=0 during the sweep, then req0 accepted first.
REQ-037 rst=0 asynchronously while wa3=3 in CLEAR -> all outputs 0 at once; after release the sweep restarts at wa3=0.
REQ-038 req1_valid=1 held during CLEAR with addr=7 and data=5A -> ready stays 0; accepted in the first RUN cycle; next cycle wa3=7, wd3=5A.

Source files
------------

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: zero-sweeps the register file after reset or clear, then
// arbitrates two write requesters round-robin onto a single registered write port.
module rf_write_scheduler #(
  parameter int N = 8,
  parameter int A = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         req0_valid,
  input  logic [A-1:0] req0_addr,
  input  logic [N-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [A-1:0] req1_addr,
  input  logic [N-1:0] req1_data,
  output logic         req1_ready,
  output logic         we3,
  output logic [A-1:0] wa3,
  output logic [N-1:0] wd3,
  output logic         grant_id,
  output logic         init_done
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [A-1:0] LAST = '1;
  state_t       state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d, wa_q, wa_d;
  logic [N-1:0] wd_q, wd_d;
  logic         ptr_q, ptr_d, we_q, we_d, gid_q, gid_d, init_q, init_d, run_ok;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      gid_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      gid_q   <= gid_d;
      init_q  <= init_d;
    end
  end
  // On a tie the requester that was not served last wins.
  assign run_ok     = (state_q == RUN) && !clr;
  assign req0_ready = run_ok && req0_valid && (!req1_valid || ptr_q);
  assign req1_ready = run_ok && req1_valid && (!req0_valid || !ptr_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    gid_d   = gid_q;
    init_d  = init_q;
    if (state_q == CLEAR) begin
      we_d  = 1'b1;
      wa_d  = cnt_q;
      wd_d  = '0;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = RUN;
        init_d  = 1'b1;
        cnt_d   = '0;
      end
    end else begin
      if (clr) begin
        state_d = CLEAR;
        cnt_d   = '0;
        init_d  = 1'b0;
      end
      if (req0_ready || req1_ready) begin
        we_d  = 1'b1;
        wa_d  = req1_ready ? req1_addr : req0_addr;
        wd_d  = req1_ready ? req1_data : req0_data;
        gid_d = req1_ready;
        ptr_d = req1_ready;
      end
    end
  end
  assign we3       = we_q;
  assign wa3       = wa_q;
  assign wd3       = wd_q;
  assign grant_id  = gid_q;
  assign init_done = init_q;
endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb_rf_write_scheduler: directed vector table for RUN-mode arbitration plus
// hand-written sequences for sweep, soft clear and asynchronous reset.
module tb_rf_write_scheduler;
  logic       clk, rst, clr;
  logic       v0, v1, r0, r1, we3, grant_id, init_done;
  logic [2:0] a0, a1, wa3;
  logic [7:0] d0, d1, wd3;
  int checks = 0, failures = 0;

  rf_write_scheduler #(.N(8), .A(3)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .we3(we3), .wa3(wa3), .wd3(wd3), .grant_id(grant_id), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v0; logic [2:0] a0; logic [7:0] d0;
    logic v1; logic [2:0] a1; logic [7:0] d1;
    logic c;
    logic r0; logic r1;
    logic we; logic [2:0] wa; logic [7:0] wd; logic gid; logic init;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rdy(input string nm, input logic e0, input logic e1);
    chk({nm, ".req0_ready"}, {31'd0, r0}, {31'd0, e0});
    chk({nm, ".req1_ready"}, {31'd0, r1}, {31'd0, e1});
  endtask

  task automatic chk_out(input string nm, input logic we, input logic [2:0] wa,
                         input logic [7:0] wd, input logic gid, input logic init);
    chk({nm, ".we3"}, {31'd0, we3}, {31'd0, we});
    chk({nm, ".wa3"}, {29'd0, wa3}, {29'd0, wa});
    chk({nm, ".wd3"}, {24'd0, wd3}, {24'd0, wd});
    chk({nm, ".grant_id"}, {31'd0, grant_id}, {31'd0, gid});
    chk({nm, ".init_done"}, {31'd0, init_done}, {31'd0, init});
  endtask

  task automatic sweep(input string nm, input logic gid, input int clr_at);
    for (int i = 0; i < 8; i++) begin
      clr = (i == clr_at);
      #1;
      chk_rdy($sformatf("%s[%0d]", nm, i), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_out($sformatf("%s[%0d]", nm, i), 1'b1, 3'(i), 8'h00, gid, i == 7);
    end
    clr = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'd4, 8'hFF, 1'b1, 3'd2, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 8'hFF, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 3'd4, 8'hFF, 1'b1, 3'd2, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'h11, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 3'd4, 8'hFF, 1'b1, 3'd2, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 8'hFF, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 3'd4, 8'hFF, 1'b1, 3'd2, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'h11, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'h11, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 3'd1, 8'hAB, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'hAB, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'hAB, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 8'h3C, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 3'd4, 8'hFF, 1'b1, 3'd2, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'h3C, 1'b1, 1'b0};
    rst = 1'b0; clr = 1'b0;
    v0 = 1'b0; a0 = '0; d0 = '0; v1 = 1'b0; a1 = '0; d1 = '0;
    #3;
    chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk_rdy("reset", 1'b0, 0);
    #9;
    rst = 1'b1;
    v1 = 1'b1; a1 = 3'd7; d1 = 8'h5A;
    sweep("sweep1", 1'b0, -1);
    #1;
    chk_rdy("first_run", 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_out("held_req1", 1'b1, 3'd7, 8'h5A, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      v0 = tbl[k].v0; a0 = tbl[k].a0; d0 = tbl[k].d0;
      v1 = tbl[k].v1; a1 = tbl[k].a1; d1 = tbl[k].d1;
      clr = tbl[k].c;
      #1;
      chk_rdy($sformatf("vec%0d", k), tbl[k].r0, tbl[k].r1);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", k), tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].gid, tbl[k].init);
    end
    sweep("sweep2", 1'b1, 3);
    #1;
    chk_rdy("after_clr", 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_out("after_clr", 1'b1, 3'd4, 8'hFF, 1'b0, 1'b1);
    v0 = 1'b0; v1 = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    chk_out("clr_edge", 1'b0, 3'd4, 8'hFF, 1'b0, 1'b0);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk_out("pre_abort", 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    v0 = 1'b1; v1 = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk_rdy("async_rst", 1'b0, 1'b0);
    v0 = 1'b0; v1 = 1'b0;
    #1;
    rst = 1'b1;
    sweep("sweep3", 1'b0, -1);
    @(posedge clk); #1;
    chk_out("idle_after_sweep", 1'b0, 3'd7, 8'h00, 1'b0, 1'b1);
    v0 = 1'b1; v1 = 1'b1;
    #1;
    chk_rdy("tie_after_reset", 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
